// File: rtl/cache_arb_pkg.sv
// Shared defaults and FSM encoding for cache_port_arbiter and its round-robin core.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BANK_W     = 2;

    localparam logic [0:0] ST_ISSUE = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    typedef logic [BANK_W-1:0] bank_t;

endpackage

// File: rtl/cache_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves one past each winner.
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [PTR_W-1:0] ptr_q;
    int               cand;

    // Search upward from the pointer with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!grant_vld && req[PTR_W'(cand)]) begin
                    grant_vld               = 1'b1;
                    grant[PTR_W'(cand)]     = 1'b1;
                    grant_idx               = PTR_W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (grant_vld) begin
            ptr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of the L1 CPU port with response routing and miss stall.
// Optional per-requester hit/miss counters are built when CACHE_ARB_PERF_EN is defined.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MISS_STALL = 2,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_hit,
    output logic                      rsp_miss,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [BANK_W-1:0]         rsp_bank,
    output logic                      cache_req,
    output logic                      cache_write,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [DATA_W-1:0]         cache_wdata,
    input  logic                      cache_hit,
    input  logic                      cache_miss,
    input  logic [DATA_W-1:0]         cache_rdata,
    input  logic [BANK_W-1:0]         cache_bank,
    input  logic                      perf_clr,
    output logic [NUM_REQ*CNT_W-1:0]  perf_hits,
    output logic [NUM_REQ*CNT_W-1:0]  perf_misses
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int STALL_W = (MISS_STALL > 1) ? $clog2(MISS_STALL) : 1;
    localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'((MISS_STALL > 1) ? MISS_STALL - 1 : 0);

    logic [0:0]         state_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               issued_p1;
    logic [ID_W-1:0]    id_p1;

    logic               stall_now;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;

    // The response cycle of a miss already counts as the first idle issue cycle.
    assign stall_now = (MISS_STALL > 0) && issued_p1 && cache_miss;
    assign arb_en    = reset_n && (state_q == ST_ISSUE) && !stall_now;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // ---- stage p0: issue winner's access to the cache
    assign req_ready = grant;
    assign cache_req = grant_vld;

    always_comb begin
        cache_write = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cache_write = req_write[i];
                cache_addr  = req_addr[i*ADDR_W +: ADDR_W];
                cache_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_p1 <= 1'b0;
            id_p1     <= '0;
        end else begin
            issued_p1 <= grant_vld;
            if (grant_vld) id_p1 <= grant_idx;
        end
    end

    // ---- stage p1: route the cache's registered response; the cache holds flags between
    // accesses, so only issued_p1 qualifies them.
    always_comb begin
        rsp_valid = '0;
        rsp_hit   = 1'b0;
        rsp_miss  = 1'b0;
        rsp_rdata = '0;
        rsp_bank  = '0;
        if (issued_p1) begin
            rsp_valid[id_p1] = 1'b1;
            rsp_hit          = cache_hit;
            rsp_miss         = cache_miss;
            rsp_rdata        = cache_rdata;
            rsp_bank         = cache_bank;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ISSUE;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (stall_now && (MISS_STALL > 1)) begin
                        state_q     <= ST_STALL;
                        stall_cnt_q <= STALL_INIT;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt_q <= STALL_W'(1)) begin
                        state_q     <= ST_ISSUE;
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q - STALL_W'(1);
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic [CNT_W-1:0] hit_cnt  [NUM_REQ];
    logic [CNT_W-1:0] miss_cnt [NUM_REQ];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_cnt[i]  <= '0;
                miss_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (perf_clr) begin
                    hit_cnt[i]  <= '0;
                    miss_cnt[i] <= '0;
                end else if (rsp_valid[i]) begin
                    if (rsp_hit)  hit_cnt[i]  <= sat_inc(hit_cnt[i]);
                    if (rsp_miss) miss_cnt[i] <= sat_inc(miss_cnt[i]);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_hits[i*CNT_W +: CNT_W]   = hit_cnt[i];
            perf_misses[i*CNT_W +: CNT_W] = miss_cnt[i];
        end
    end
`else
    logic perf_clr_unused;
    assign perf_clr_unused = perf_clr;
    assign perf_hits       = '0;
    assign perf_misses     = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: a small direct-mapped cache environment plus an abstract arbitration model.
module tb_cache_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic            rsp_hit, rsp_miss;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_bank;
    logic            cache_req, cache_write;
    logic [AW-1:0]   cache_addr;
    logic [DW-1:0]   cache_wdata;
    logic            cache_hit = 1'b0, cache_miss = 1'b0;
    logic [DW-1:0]   cache_rdata = '0;
    logic [1:0]      cache_bank = '0;
    logic            perf_clr = 1'b0;
    logic [N*CW-1:0] perf_hits, perf_misses;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MISS_STALL(MS), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss),
        .rsp_rdata(rsp_rdata), .rsp_bank(rsp_bank),
        .cache_req(cache_req), .cache_write(cache_write), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_hit(cache_hit), .cache_miss(cache_miss), .cache_rdata(cache_rdata), .cache_bank(cache_bank),
        .perf_clr(perf_clr), .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    // Cache environment: word-granular direct-mapped, index addr[9:2], tag addr[31:10], bank addr[5:4].
    logic [DW-1:0] mem    [int unsigned];
    int unsigned   tag_of [int unsigned];

    function automatic bit env_hit(input logic [AW-1:0] a);
        int unsigned idx;
        idx = 32'(a[9:2]);
        return tag_of.exists(idx) && (tag_of[idx] == 32'(a[31:10]));
    endfunction

    function automatic logic [DW-1:0] env_word(input logic [AW-1:0] a);
        int unsigned key;
        key = 32'(a[31:2]);
        return mem.exists(key) ? mem[key] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic void env_warm(input logic [AW-1:0] a);
        tag_of[32'(a[9:2])] = 32'(a[31:10]);
    endfunction

    function automatic void env_access(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        if (w) mem[32'(a[31:2])] = d;
        env_warm(a);
    endfunction

    always @(posedge clk) begin
        if (cache_req) begin
            cache_hit   <= env_hit(cache_addr);
            cache_miss  <= !env_hit(cache_addr);
            cache_bank  <= cache_addr[5:4];
            cache_rdata <= cache_write ? cache_wdata : env_word(cache_addr);
            env_access(cache_addr, cache_write, cache_wdata);
        end
    end

    // Reference model: pointer, pending response, idle budget and counters as plain integers.
    int            m_ptr = 0, m_pid = 0, m_idle = 0, m_gnt = -1;
    bit            m_pend = 0, m_phit = 0, m_pmiss = 0;
    logic [DW-1:0] m_pdata = '0;
    logic [1:0]    m_pbank = '0;
    int            m_hits [N];
    int            m_misses [N];

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_pend = 0; m_idle = 0; m_gnt = -1;
        for (int i = 0; i < N; i++) begin m_hits[i] = 0; m_misses[i] = 0; end
    endfunction

    function automatic void eval_model();
        bit blocked;
        if (!reset_n) model_reset();
        blocked = !reset_n || (m_idle > 0) || (m_pend && m_pmiss && MS > 0);
        m_gnt = -1;
        if (!blocked)
            for (int k = 0; k < N; k++)
                if (m_gnt < 0 && req_valid[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
    endfunction

    function automatic void commit_model();
        bit was_miss;
        logic [AW-1:0] a;
        if (!reset_n) begin model_reset(); return; end
        was_miss = m_pend && m_pmiss;
        for (int i = 0; i < N; i++) begin
            if (perf_clr) begin m_hits[i] = 0; m_misses[i] = 0; end
            else if (m_pend && m_pid == i) begin
                if (m_phit)  m_hits[i]   = (m_hits[i]   < 65535) ? m_hits[i] + 1   : 65535;
                if (m_pmiss) m_misses[i] = (m_misses[i] < 65535) ? m_misses[i] + 1 : 65535;
            end
        end
        if (m_gnt >= 0) begin
            a       = addr_of(m_gnt);
            m_pend  = 1;
            m_pid   = m_gnt;
            m_phit  = env_hit(a);
            m_pmiss = !m_phit;
            m_pdata = req_write[m_gnt] ? req_wdata[m_gnt*DW +: DW] : env_word(a);
            m_pbank = a[5:4];
            m_ptr   = (m_gnt + 1) % N;
        end else begin
            m_pend = 0;
        end
        if (was_miss && MS > 0) m_idle = MS - 1;
        else if (m_idle > 0)    m_idle = m_idle - 1;
    endfunction

    task automatic at_neg();
        @(negedge clk);
        eval_model();
    endtask

    task automatic next_cycle();
        commit_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req_valid = '0;
        perf_clr  = 1'b0;
        reset_n   = 1'b0;
        repeat (2) begin at_neg(); next_cycle(); end
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        set_req(1, 1'b1, 1'b1, 32'h0000_0504, 32'h1234_5678);
        set_req(2, 1'b1, 1'b0, 32'h0000_0508, '0);
        at_neg();
        n_checks++; if (req_ready !== '0) begin n_errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        n_checks++; if (cache_req !== 1'b0) begin n_errors++; $display("FAIL reset_cache_req got %b exp 0", cache_req); end
        n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 000", rsp_valid); end
        n_checks++; if ({rsp_hit, rsp_miss, rsp_bank, rsp_rdata} !== '0) begin n_errors++;
            $display("FAIL reset_rsp_fields got hit=%b miss=%b bank=%0d rdata=%h exp all 0", rsp_hit, rsp_miss, rsp_bank, rsp_rdata); end
        n_checks++; if ({perf_hits, perf_misses} !== '0) begin n_errors++;
            $display("FAIL reset_perf got hits=%h misses=%h exp 0", perf_hits, perf_misses); end
        next_cycle();
        req_valid = '0;
        reset_n   = 1'b1;
    endtask

    task automatic test_miss_then_hit();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0040, '0);
        at_neg();
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL miss_grant got %b exp 001", req_ready); end
        n_checks++; if (cache_addr !== 32'h40) begin n_errors++; $display("FAIL miss_addr got %h exp 00000040", cache_addr); end
        next_cycle();
        for (int c = 1; c <= MS; c++) begin
            at_neg();
            if (c == 1) begin
                n_checks++; if (rsp_valid !== 3'b001 || rsp_miss !== 1'b1 || rsp_hit !== 1'b0 || rsp_bank !== 2'd0) begin
                    n_errors++; $display("FAIL miss_rsp got valid=%b miss=%b hit=%b bank=%0d exp 001/1/0/0", rsp_valid, rsp_miss, rsp_hit, rsp_bank); end
            end else begin
                n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL miss_idle_rsp c=%0d got %b exp 000", c, rsp_valid); end
            end
            n_checks++; if (req_ready !== '0 || cache_req !== 1'b0) begin
                n_errors++; $display("FAIL miss_stall c=%0d got ready=%b req=%b exp 000/0", c, req_ready, cache_req); end
            next_cycle();
        end
        at_neg();
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL miss_regrant got %b exp 001", req_ready); end
        next_cycle();
        req_valid = '0;
        at_neg();
        n_checks++; if (rsp_valid !== 3'b001 || rsp_hit !== 1'b1 || rsp_rdata !== 32'hC0DE_0040) begin
            n_errors++; $display("FAIL repeat_hit got valid=%b hit=%b rdata=%h exp 001/1/c0de0040", rsp_valid, rsp_hit, rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_alternate();
        logic [N-1:0] prev, exp_g;
        do_reset();
        env_warm(32'h200);
        env_warm(32'h300);
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, '0);
        prev = '0;
        for (int c = 0; c < 8; c++) begin
            exp_g = (c % 2 == 0) ? 3'b001 : 3'b010;
            at_neg();
            n_checks++; if (req_ready !== exp_g) begin n_errors++; $display("FAIL alt_grant c=%0d got %b exp %b", c, req_ready, exp_g); end
            if (c > 0) begin
                n_checks++; if (rsp_valid !== prev || rsp_hit !== 1'b1 ||
                                rsp_rdata !== (prev == 3'b001 ? 32'hC0DE_0200 : 32'hC0DE_0300)) begin
                    n_errors++; $display("FAIL alt_rsp c=%0d got valid=%b hit=%b rdata=%h exp valid=%b", c, rsp_valid, rsp_hit, rsp_rdata, prev); end
            end
            prev = exp_g;
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_miss_stall();
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'h0000_1000, '0);
        at_neg();
        n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL stall_grant got %b exp 010", req_ready); end
        next_cycle();
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        for (int c = 1; c <= MS; c++) begin
            at_neg();
            if (c == 1) begin
                n_checks++; if (rsp_valid !== 3'b010 || rsp_miss !== 1'b1) begin
                    n_errors++; $display("FAIL stall_rsp got valid=%b miss=%b exp 010/1", rsp_valid, rsp_miss); end
            end
            n_checks++; if (req_ready !== '0) begin n_errors++; $display("FAIL stall_idle c=%0d got %b exp 000", c, req_ready); end
            next_cycle();
        end
        at_neg();
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL stall_release got %b exp 001", req_ready); end
        next_cycle();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, '0);
        at_neg();
        n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL rmid_grant got %b exp 010", req_ready); end
        next_cycle();
        reset_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0400, '0);
        repeat (2) begin
            at_neg();
            n_checks++; if (rsp_valid !== '0 || req_ready !== '0) begin
                n_errors++; $display("FAIL rmid_in_reset got rsp=%b ready=%b exp 000/000", rsp_valid, req_ready); end
            next_cycle();
        end
        reset_n = 1'b1;
        at_neg();
        n_checks++; if (rsp_valid !== '0) begin n_errors++; $display("FAIL rmid_stale_rsp got %b exp 000", rsp_valid); end
        n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL rmid_first_grant got %b exp 001", req_ready); end
        next_cycle();
        req_valid = '0;
        at_neg();
        n_checks++; if (rsp_valid !== 3'b001) begin n_errors++; $display("FAIL rmid_rsp got %b exp 001", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_write_read();
        do_reset();
        env_warm(32'h100);
        set_req(0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        at_neg();
        n_checks++; if (req_ready !== 3'b001 || cache_write !== 1'b1 || cache_wdata !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL wr_issue got ready=%b write=%b wdata=%h exp 001/1/deadbeef", req_ready, cache_write, cache_wdata); end
        next_cycle();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h0000_0100, '0);
        at_neg();
        n_checks++; if (req_ready !== 3'b010 || rsp_valid !== 3'b001 || rsp_hit !== 1'b1) begin
            n_errors++; $display("FAIL rd_issue got ready=%b rsp=%b hit=%b exp 010/001/1", req_ready, rsp_valid, rsp_hit); end
        next_cycle();
        req_valid = '0;
        at_neg();
        n_checks++; if (rsp_valid !== 3'b010 || rsp_hit !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL rd_rsp got valid=%b hit=%b rdata=%h exp 010/1/deadbeef", rsp_valid, rsp_hit, rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_perf();
        logic [AW-1:0] addrs [5];
        int exp_h, exp_m;
        bit got;
        addrs = '{32'h0000_0200, 32'h0000_0300, 32'h0000_0100, 32'h0000_2000, 32'h0000_3004};
`ifdef CACHE_ARB_PERF_EN
        exp_h = 3; exp_m = 2;
`else
        exp_h = 0; exp_m = 0;
`endif
        do_reset();
        for (int a = 0; a < 5; a++) begin
            got = 1'b0;
            set_req(0, 1'b1, 1'b0, addrs[a], '0);
            for (int w = 0; w < 8 && !got; w++) begin
                at_neg();
                got = req_ready[0];
                next_cycle();
            end
            req_valid[0] = 1'b0;
            n_checks++; if (!got) begin n_errors++; $display("FAIL perf_grant_wait access=%0d got no grant exp grant within 8 cycles", a); end
        end
        repeat (MS + 2) begin at_neg(); next_cycle(); end
        at_neg();
        n_checks++; if (perf_hits[0 +: CW] !== CW'(exp_h) || perf_misses[0 +: CW] !== CW'(exp_m)) begin
            n_errors++; $display("FAIL perf_counts got hits=%0d misses=%0d exp %0d/%0d", perf_hits[0 +: CW], perf_misses[0 +: CW], exp_h, exp_m); end
        n_checks++; if (perf_hits[CW +: CW] !== '0 || perf_misses[CW +: CW] !== '0) begin
            n_errors++; $display("FAIL perf_other got hits=%0d misses=%0d exp 0/0", perf_hits[CW +: CW], perf_misses[CW +: CW]); end
        next_cycle();
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, '0);
        at_neg();
        next_cycle();
        req_valid[0] = 1'b0;
        perf_clr = 1'b1;
        at_neg();
        next_cycle();
        perf_clr = 1'b0;
        at_neg();
        n_checks++; if (perf_hits !== '0 || perf_misses !== '0) begin
            n_errors++; $display("FAIL perf_clear got hits=%h misses=%h exp 0", perf_hits, perf_misses); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [N-1:0]    e_rdy, e_rsp;
        logic [N*CW-1:0] e_ph, e_pm;
        int              last_gnt;
        last_gnt = -1;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && i != last_gnt && $urandom_range(0, 9) != 0))
                    set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                            32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 4)),
                            $urandom);
            end
            perf_clr = ($urandom_range(0, 39) == 0);
            at_neg();
            e_rdy = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
            e_rsp = m_pend ? (N'(1) << m_pid) : '0;
            e_ph = '0;
            e_pm = '0;
`ifdef CACHE_ARB_PERF_EN
            for (int i = 0; i < N; i++) begin
                e_ph[i*CW +: CW] = CW'(m_hits[i]);
                e_pm[i*CW +: CW] = CW'(m_misses[i]);
            end
`endif
            n_checks++; if (req_ready !== e_rdy || cache_req !== (m_gnt >= 0)) begin
                n_errors++; $display("FAIL rnd_grant c=%0d got ready=%b req=%b exp %b", c, req_ready, cache_req, e_rdy); end
            if (m_gnt >= 0) begin
                n_checks++; if (cache_addr !== addr_of(m_gnt) || cache_write !== req_write[m_gnt] ||
                                (req_write[m_gnt] && cache_wdata !== req_wdata[m_gnt*DW +: DW])) begin
                    n_errors++; $display("FAIL rnd_mux c=%0d got addr=%h wr=%b exp addr=%h", c, cache_addr, cache_write, addr_of(m_gnt)); end
            end
            n_checks++; if (rsp_valid !== e_rsp) begin n_errors++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, e_rsp); end
            if (m_pend) begin
                n_checks++; if (rsp_hit !== m_phit || rsp_miss !== m_pmiss || rsp_rdata !== m_pdata || rsp_bank !== m_pbank) begin
                    n_errors++; $display("FAIL rnd_rsp_data c=%0d got hit=%b miss=%b rdata=%h bank=%0d exp %b/%b/%h/%0d",
                                         c, rsp_hit, rsp_miss, rsp_rdata, rsp_bank, m_phit, m_pmiss, m_pdata, m_pbank); end
            end
            n_checks++; if (perf_hits !== e_ph || perf_misses !== e_pm) begin
                n_errors++; $display("FAIL rnd_perf c=%0d got hits=%h misses=%h exp %h/%h", c, perf_hits, perf_misses, e_ph, e_pm); end
            last_gnt = m_gnt;
            next_cycle();
        end
        req_valid = '0;
        perf_clr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_miss_then_hit();
        test_alternate();
        test_miss_stall();
        test_reset_mid();
        test_write_read();
        test_perf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single CPU-side port of the banked direct-mapped L1 cache between NUM_REQ requesters (e.g. fetch and load/store units). Arbitration is round-robin and issues at most one access per cycle. The block tags each issued access with its requester ID and routes the cache's registered response (one cycle later) back to that requester. After a miss, it inserts a configurable number of idle cycles to model refill occupancy of the memory port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, word width
MISS_STALL, 2, idle issue cycles after a miss response; 0 = no stall
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle after grant
rsp_hit  out  1  hit flag of current response
rsp_miss  out  1  miss flag of current response
rsp_rdata  out  DATA_W  read data of current response
rsp_bank  out  2  bank accessed by current response
cache_req  out  1  to cache cpu_req
cache_write  out  1  to cache cpu_write
cache_addr  out  ADDR_W  to cache cpu_addr
cache_wdata  out  DATA_W  to cache cpu_write_data
cache_hit  in  1  cache registered hit
cache_miss  in  1  cache registered miss
cache_rdata  in  DATA_W  cache registered read data
cache_bank  in  2  cache registered accessed_bank
perf_clr  in  1  synchronous clear of perf counters
perf_hits  out  NUM_REQ*CNT_W  per-requester hit counts
perf_misses  out  NUM_REQ*CNT_W  per-requester miss counts

Behaviour:
- Reset (reset_n low, asynchronous): state=ISSUE, rr pointer=0, issued_q=0, id_q=0, stall count=0. All outputs read 0 while in reset: req_ready, rsp_valid, rsp_hit, rsp_miss, rsp_rdata, rsp_bank, cache_req, perf_*.
- States: ISSUE (grants allowed), STALL (no grants).
- ISSUE, cycle T: the first valid requester at or after the rr pointer, searching upward with wrap, gets req_ready=1. Combinationally, cache_req=1 and cache_write/addr/wdata are muxed from the winner. At edge: issued_q<=1, id_q<=winner, pointer<=(winner+1) mod NUM_REQ. With no valid requester: cache_req=0, issued_q<=0, pointer unchanged.
- Cycle T+1: if issued_q, then rsp_valid[id_q]=1, rsp_hit=cache_hit, rsp_miss=cache_miss, rsp_rdata=cache_rdata, rsp_bank=cache_bank. Otherwise all rsp_* are 0. The cache holds hit/miss between requests, so responses must be qualified by issued_q only.
- Miss with MISS_STALL>0: in the response cycle, grants are suppressed combinationally (cache_req=0). The block enters STALL with count=MISS_STALL-1 and decrements each cycle, returning to ISSUE when it reaches 0. Total idle issue cycles = MISS_STALL.
- MISS_STALL=0: no suppression; a new grant may coincide with any response.
- Back-to-back hits: one grant per cycle; a requester may be granted in consecutive cycles only if no other requester is valid.
- Requesters hold req_valid and payload until ready. Dropping valid before grant is legal.
- Reset mid-transaction: the pending response is discarded (no rsp_valid after reset release).

Optional Feature:
CACHE_ARB_PERF_EN: when defined, each requester has CNT_W-bit hit and miss counters. They increment on a hit or miss response, saturate at all-ones, and clear on perf_clr (clear wins over a same-cycle increment). When undefined, the counters are not built and perf_hits/perf_misses are tied to 0; the ports remain present.

Decomposition:
- Package cache_arb_pkg: ADDR_W/DATA_W defaults, BANK_W=2, state encoding (ISSUE, STALL).
- Sub-module rr_arbiter: NUM_REQ-wide round-robin one-hot grant with pointer update.
- Muxing, ID pipeline, stall counter and perf counters stay in the top.

Test Plan:
1. Read of 0x0000_0040 from req0 after reset against the real cache with a memory model. Response in T+1 with rsp_valid=01, rsp_miss=1, rsp_bank=0. No grant for 2 cycles; the repeat read hits with the line word.
2. req0 and req1 held valid continuously, all hits. Grants alternate 01,10,01,10; each rsp_valid matches the grant from the previous cycle; rsp_rdata is routed correctly.
3. MISS_STALL=3; req1 misses at T. req_ready=0 in T+1..T+3 despite req0 valid; req0 is granted in T+4.
4. reset_n pulsed low in the cycle after a grant. rsp_valid=0 throughout; the first grant after release goes to req0 (pointer 0).
5. CACHE_ARB_PERF_EN defined; req0 gets 3 hits and 2 misses. perf_hits[0]=3, perf_misses[0]=2. Counters forced to 0xFFFF stay at 0xFFFF on a further hit; perf_clr gives 0.
6. req0 writes 0xDEAD_BEEF to 0x100 at T, req1 reads 0x100 at T+1. req1's response in T+2 has rsp_rdata=0xDEAD_BEEF and rsp_hit=1.
